// File: rtl/ant_ph_map.sv
// Ant position/heading tracker with a saturating per-cell pheromone map.
// A background sweep decrements every cell once per evaporation period.
//   state   | meaning
//   S_WAIT  | counting down the idle interval before the next sweep
//   S_SWEEP | decrementing one cell per cycle, pointer 0 .. last cell
module ant_ph_map #(
  parameter int X_W         = 4,
  parameter int Y_W         = 4,
  parameter int PH_WIDTH    = 2,
  parameter int START_X     = 0,
  parameter int START_Y     = 0,
  parameter int START_DIR   = 1,
  parameter int EVAP_PERIOD = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          move,
  input  logic                blocked,
  input  logic [PH_WIDTH-1:0] ph_drop,
  output logic [PH_WIDTH-1:0] ph_detected,
  output logic [X_W-1:0]      pos_x,
  output logic [Y_W-1:0]      pos_y,
  output logic [1:0]          heading,
  output logic                edge_bump,
  output logic [15:0]         step_count,
  output logic                sweeping
);

  localparam int A_W     = X_W + Y_W;
  localparam int N_CELLS = 1 << A_W;
  localparam int CNT_W   = (EVAP_PERIOD > 1) ? $clog2(EVAP_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (EVAP_PERIOD > 0) ? CNT_W'(EVAP_PERIOD - 1) : '0;
  localparam logic [PH_WIDTH-1:0] PH_MAX = '1;

  localparam logic [1:0] MV_RIGHT   = 2'b01;
  localparam logic [1:0] MV_LEFT    = 2'b10;
  localparam logic [1:0] MV_FORWARD = 2'b11;

  typedef enum logic {S_WAIT, S_SWEEP} evap_state_t;

  evap_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [A_W-1:0]      r_ptr, w_ptr_nxt;
  logic                w_decay;

  logic [PH_WIDTH-1:0] r_map [N_CELLS];
  logic [X_W-1:0]      r_pos_x;
  logic [Y_W-1:0]      r_pos_y;
  logic [1:0]          r_heading;
  logic                r_edge_bump;
  logic [15:0]         r_step_count;

  logic                w_fwd;
  logic                w_at_edge;
  logic [A_W-1:0]      w_cur_idx;
  logic                w_dep;
  logic [PH_WIDTH:0]   w_sum;
  logic [PH_WIDTH-1:0] w_dep_val;
  logic [PH_WIDTH-1:0] w_dec_val;

  assign w_fwd     = (move == MV_FORWARD) && !blocked;
  assign w_cur_idx = {r_pos_y, r_pos_x};

  always_comb begin
    w_at_edge = 1'b0;
    case (r_heading)
      2'd0:    w_at_edge = (r_pos_y == '1);
      2'd1:    w_at_edge = (r_pos_x == '1);
      2'd2:    w_at_edge = (r_pos_y == '0);
      default: w_at_edge = (r_pos_x == '0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pos_x      <= X_W'(START_X);
      r_pos_y      <= Y_W'(START_Y);
      r_heading    <= 2'(START_DIR);
      r_edge_bump  <= 1'b0;
      r_step_count <= '0;
    end else begin
      case (move)
        MV_RIGHT: r_heading <= r_heading + 2'd1;
        MV_LEFT:  r_heading <= r_heading - 2'd1;
        default:  ;
      endcase
      r_edge_bump <= w_fwd && w_at_edge;
      if (w_fwd && !w_at_edge) begin
        case (r_heading)
          2'd0:    r_pos_y <= r_pos_y + 1'b1;
          2'd1:    r_pos_x <= r_pos_x + 1'b1;
          2'd2:    r_pos_y <= r_pos_y - 1'b1;
          default: r_pos_x <= r_pos_x - 1'b1;
        endcase
        if (r_step_count != 16'hFFFF) r_step_count <= r_step_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_decay     = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (EVAP_PERIOD != 0) begin
          if (r_cnt == '0) begin
            w_state_nxt = S_SWEEP;
            w_ptr_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      default: begin
        w_decay   = 1'b1;
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == '1) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
      r_cnt   <= CNT_LOAD;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign w_dep     = (ph_drop != '0);
  assign w_sum     = {1'b0, r_map[w_cur_idx]} + {1'b0, ph_drop};
  assign w_dep_val = w_sum[PH_WIDTH] ? PH_MAX : w_sum[PH_WIDTH-1:0];
  assign w_dec_val = (r_map[r_ptr] == '0) ? '0 : r_map[r_ptr] - 1'b1;

  // A deposit on the cell under the sweep pointer wins; that cell skips decay.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CELLS; i++) r_map[i] <= '0;
    end else begin
      if (w_decay && !(w_dep && (r_ptr == w_cur_idx))) r_map[r_ptr] <= w_dec_val;
      if (w_dep) r_map[w_cur_idx] <= w_dep_val;
    end
  end

  assign ph_detected = r_map[w_cur_idx];
  assign pos_x       = r_pos_x;
  assign pos_y       = r_pos_y;
  assign heading     = r_heading;
  assign edge_bump   = r_edge_bump;
  assign step_count  = r_step_count;
  assign sweeping    = (r_state == S_SWEEP);

endmodule

// File: tb/tb_ant_ph_map.sv
// Directed bench: vector table on a 16x16 map without evaporation, plus
// hand sequences on a 4x4 map with an 8-cycle evaporation period.
module tb_ant_ph_map;

  localparam logic [1:0] H = 2'b00, R = 2'b01, L = 2'b10, F = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] move = H;
  logic       blocked = 1'b0;
  logic [1:0] ph_drop = '0;

  logic [1:0]  a_ph, a_hd;
  logic [3:0]  a_x, a_y;
  logic        a_bump, a_sw;
  logic [15:0] a_steps;

  logic [1:0]  b_ph, b_hd;
  logic [1:0]  b_x, b_y;
  logic        b_bump, b_sw;
  logic [15:0] b_steps;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ant_ph_map #(.X_W(4), .Y_W(4), .PH_WIDTH(2), .START_X(0), .START_Y(0),
               .START_DIR(1), .EVAP_PERIOD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .move(move), .blocked(blocked), .ph_drop(ph_drop),
    .ph_detected(a_ph), .pos_x(a_x), .pos_y(a_y), .heading(a_hd),
    .edge_bump(a_bump), .step_count(a_steps), .sweeping(a_sw));

  ant_ph_map #(.X_W(2), .Y_W(2), .PH_WIDTH(2), .START_X(0), .START_Y(0),
               .START_DIR(1), .EVAP_PERIOD(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .move(move), .blocked(blocked), .ph_drop(ph_drop),
    .ph_detected(b_ph), .pos_x(b_x), .pos_y(b_y), .heading(b_hd),
    .edge_bump(b_bump), .step_count(b_steps), .sweeping(b_sw));

  typedef struct {
    logic        rst_n;
    logic [1:0]  mv;
    logic        blk;
    logic [1:0]  drop;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [1:0]  hd;
    logic        bump;
    logic [15:0] steps;
    logic [1:0]  ph;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [1:0] mv, input logic blk,
                     input logic [1:0] drop, input logic [3:0] x, input logic [3:0] y,
                     input logic [1:0] hd, input logic bump, input logic [15:0] steps,
                     input logic [1:0] ph);
    vec_t v;
    v.rst_n = r; v.mv = mv; v.blk = blk; v.drop = drop; v.x = x; v.y = y;
    v.hd = hd; v.bump = bump; v.steps = steps; v.ph = ph;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; move = H; blocked = 1'b0; ph_drop = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_ph;
    int dec;

    //   rst mv blk drop  x  y hd bump steps ph
    add(0, H, 0, 0,   0, 0, 1, 0, 0, 0);
    add(1, R, 0, 0,   0, 0, 2, 0, 0, 0);
    add(1, R, 0, 0,   0, 0, 3, 0, 0, 0);
    add(1, R, 0, 0,   0, 0, 0, 0, 0, 0);
    add(1, R, 0, 0,   0, 0, 1, 0, 0, 0);
    add(1, L, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, H, 0, 0,   0, 0, 1, 0, 0, 0);
    add(1, F, 0, 0,   1, 0, 1, 0, 1, 0);
    add(1, F, 0, 0,   2, 0, 1, 0, 2, 0);
    add(1, F, 0, 0,   3, 0, 1, 0, 3, 0);
    add(1, F, 1, 0,   3, 0, 1, 0, 3, 0);
    add(0, H, 0, 0,   0, 0, 1, 0, 0, 0);
    add(1, L, 0, 0,   0, 0, 0, 0, 0, 0);
    add(1, L, 0, 0,   0, 0, 3, 0, 0, 0);
    add(1, F, 0, 0,   0, 0, 3, 1, 0, 0);
    add(1, H, 0, 0,   0, 0, 3, 0, 0, 0);
    add(1, R, 0, 0,   0, 0, 0, 0, 0, 0);
    add(1, F, 0, 0,   0, 1, 0, 0, 1, 0);
    add(1, R, 0, 0,   0, 1, 1, 0, 1, 0);
    add(1, R, 0, 0,   0, 1, 2, 0, 1, 0);
    add(1, F, 0, 0,   0, 0, 2, 0, 2, 0);
    add(1, F, 0, 0,   0, 0, 2, 1, 2, 0);
    add(1, H, 0, 0,   0, 0, 2, 0, 2, 0);
    add(0, H, 0, 0,   0, 0, 1, 0, 0, 0);
    add(1, H, 0, 1,   0, 0, 1, 0, 0, 1);
    add(1, H, 0, 1,   0, 0, 1, 0, 0, 2);
    add(1, H, 0, 1,   0, 0, 1, 0, 0, 3);
    add(1, H, 0, 1,   0, 0, 1, 0, 0, 3);
    add(1, H, 0, 1,   0, 0, 1, 0, 0, 3);
    add(1, H, 0, 2,   0, 0, 1, 0, 0, 3);
    add(1, H, 0, 0,   0, 0, 1, 0, 0, 3);
    add(1, F, 0, 0,   1, 0, 1, 0, 1, 0);
    add(1, F, 0, 2,   2, 0, 1, 0, 2, 0);
    add(1, R, 0, 0,   2, 0, 2, 0, 2, 0);
    add(1, R, 0, 0,   2, 0, 3, 0, 2, 0);
    add(1, F, 0, 0,   1, 0, 3, 0, 3, 2);
    add(1, F, 0, 0,   0, 0, 3, 0, 4, 3);

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n; move = vq[i].mv; blocked = vq[i].blk; ph_drop = vq[i].drop;
      tick();
      chk($sformatf("vec%0d {x,y,hd,bump,steps,ph}", i),
          {3'b0, a_x, a_y, a_hd, a_bump, a_steps, a_ph},
          {3'b0, vq[i].x, vq[i].y, vq[i].hd, vq[i].bump, vq[i].steps, vq[i].ph});
      chk($sformatf("vec%0d sweeping_off", i), a_sw, 1'b0);
    end

    // East boundary on the 4x4 map.
    do_reset();
    move = F;
    repeat (3) tick();
    chk("east_x3", b_x, 2'd3);
    tick();
    chk("east_bump", b_bump, 1'b1);
    chk("east_x_hold", b_x, 2'd3);
    chk("east_steps", b_steps, 16'd3);
    move = H;
    tick();
    chk("east_bump_clear", b_bump, 1'b0);

    // Evaporation timeline: deposit 3 at (0,0), decay edges at 9, 33, 57, 81.
    do_reset();
    chk("evap_reset_sweep", b_sw, 1'b0);
    ph_drop = 2'd3;
    for (int k = 1; k <= 100; k++) begin
      tick();
      ph_drop = '0;
      dec = (k >= 9) ? ((k - 9) / 24 + 1) : 0;
      exp_ph = (dec >= 3) ? 0 : 3 - dec;
      chk($sformatf("evap_sweeping_k%0d", k), b_sw, ((k % 24) >= 8));
      chk($sformatf("evap_ph_k%0d", k), b_ph, exp_ph[1:0]);
    end

    // Deposit on the cycle the sweep pointer reaches (0,0).
    do_reset();
    ph_drop = 2'd2;
    tick();
    ph_drop = '0;
    repeat (7) tick();
    chk("hit_sweeping", b_sw, 1'b1);
    ph_drop = 2'd1;
    tick();
    ph_drop = '0;
    chk("hit_no_decay", b_ph, 2'd3);
    repeat (15) tick();
    chk("hit_after_sweep", b_ph, 2'd3);
    chk("hit_sweep_done", b_sw, 1'b0);
    repeat (9) tick();
    chk("hit_next_decay", b_ph, 2'd2);

    // Reset in the middle of a sweep.
    do_reset();
    move = F; ph_drop = 2'd1; tick();
    move = F; ph_drop = 2'd2; tick();
    move = L; ph_drop = 2'd0; tick();
    move = F; ph_drop = 2'd3; tick();
    move = H; ph_drop = 2'd1; tick();
    ph_drop = '0;
    chk("mid_pos", {b_x, b_y}, {2'd2, 2'd1});
    chk("mid_ph", b_ph, 2'd1);
    chk("mid_steps", b_steps, 16'd3);
    repeat (7) tick();
    chk("mid_sweeping", b_sw, 1'b1);
    rst_n = 1'b0;
    #3;
    chk("rst_pending_pos", {b_x, b_y}, {2'd2, 2'd1});
    chk("rst_pending_sweep", b_sw, 1'b1);
    chk("rst_pending_steps", b_steps, 16'd3);
    tick();
    rst_n = 1'b1;
    chk("rst_pos", {b_x, b_y, b_hd}, {2'd0, 2'd0, 2'd1});
    chk("rst_sweep", b_sw, 1'b0);
    chk("rst_steps", b_steps, 16'd0);
    chk("rst_ph", b_ph, 2'd0);
    move = F;
    tick();
    move = H;
    chk("rst_cell_10_cleared", b_ph, 2'd0);
    chk("rst_step1", b_steps, 16'd1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk($sformatf("rst_wait_k%0d", k), b_sw, (k == 8));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
